timer_sched: RTL and testbench
==============================

// Module: timer_sched
// PURPOSE
//   Shares one external `timer` instance among NREQ requesters. Each requester asks
//   for a delay; the block grants round-robin, loads tmr_target, runs the timer
//   until its tick, then pulses done to the winner. It sits between delay users
//   (debouncers, blinkers, FSM waits) and the single timer in the lab top level.
// PARAMETERS
//   WIDTH  24  delay / tmr_target width; must equal the timer's WIDTH
//   NREQ   4   number of requesters, 2..16; IDW = $clog2(NREQ) is a localparam
// PORTS
//   clk         in   1           system clock
//   rst_n       in   1           asynchronous active-low reset
//   req         in   NREQ        level request, bit i = requester i
//   dly         in   NREQ*WIDTH  delay of requester i in bits [i*WIDTH +: WIDTH]
//   gnt         out  NREQ        one-hot grant, high for the whole service
//   done        out  NREQ        one-cycle completion pulse to the granted requester
//   busy        out  1           high while a request is in service (RUN or DONE)
//   cur_id      out  IDW         index of the current/last granted requester
//   tmr_en      out  1           timer enable
//   tmr_target  out  WIDTH       timer target_time
//   tmr_tick    in   1           timer tick (1-cycle registered pulse)
// BEHAVIOUR
//   - Timer contract: tmr_en low clears the count. First tick is registered d+1
//     edges after the first edge that samples tmr_en=1, where d = tmr_target.
//   - All outputs are registered. Reset: state=IDLE, gnt=0, done=0, busy=0,
//     cur_id=0, tmr_en=0, tmr_target=0, rr pointer=0 (req[0] has top priority).
//   - FSM IDLE -> RUN -> DONE -> IDLE:
//     IDLE: tmr_en=0. On edge E0 with any req set, pick the first set bit searching
//       from ptr upward with wrap. Then gnt<=onehot(k), cur_id<=k,
//       tmr_target<=dly[k], tmr_en<=1, busy<=1, and go to RUN.
//     RUN: hold tmr_target and tmr_en. dly is sampled only at grant; later changes
//       are ignored. On the edge that samples tmr_tick=1, set done[k]<=1,
//       tmr_en<=0, gnt<=0, ptr<=(k+1) mod NREQ, and go to DONE.
//     DONE: done drops after one cycle. busy stays high. Go to IDLE on the next edge.
//       This lets the requester drop req before it is arbitrated again.
//   - Latency: grant at E0, done visible after edge E0+d+2. With d=0, done follows
//     2 edges after grant. Back-to-back grants are spaced d+4 edges apart.
//   - tmr_en is low for at least 2 edges between services, so the timer count is 0
//     at every new grant.
//   - tmr_tick outside RUN is ignored. req bits that are not granted are ignored
//     in RUN. A requester holding req through DONE is granted again only after
//     the other pending requesters (ptr has moved past it).
//   - dly = all-ones is legal. No overflow handling is needed because the timer
//     compares with >=.
//   - rst_n low at any time, including mid-RUN, forces the reset values
//     immediately. No done is emitted for the interrupted request.
// CONFIGURATION
//   TSCHED_ABORT_EN defined: in RUN, if req[k] samples 0, then tmr_en<=0, gnt<=0,
//     no done, ptr<=(k+1) mod NREQ, and go to IDLE. Abort beats a tick sampled on
//     the same edge.
//   TSCHED_ABORT_EN undefined: req[k] is not checked in RUN. Service always runs
//     to tick and done.
// TESTING
//   1 Assert rst_n=0 mid-stream -> all outputs 0 within the reset cycle, FSM in IDLE.
//   2 req=0001, dly0=5 -> gnt=0001 at E0, tmr_target=5, done=0001 for 1 cycle
//     after E7, busy low after E8.
//   3 req=0010, dly1=0 -> done[1] pulse after E2; tmr_en high exactly 2 cycles.
//   4 req=1111 held, all dly=2, each req drops after its done -> grant order
//     0,1,2,3, grant spacing 6 edges, exactly 4 done pulses.
//   5 req0 and req1 held permanently, dly=3 -> grants alternate 0,1,0,1;
//     tmr_en low for >=2 edges between grants.
//   6 Build with TSCHED_ABORT_EN, dly0=10, drop req0 at E4 -> tmr_en=0 and gnt=0
//     after E5, no done, IDLE. Build without it, same stimulus -> done[0] after E12.

Source files
------------

// File: rtl/timer_sched.sv
// timer_sched: round-robin sharing of one external timer among NREQ delay requesters.
// Optional macro TSCHED_ABORT_EN: dropping req of the granted requester aborts its service.
// Revision: 1.0
`default_nettype none

module timer_sched #(
  parameter int WIDTH = 24,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] dly,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [IDW-1:0]        cur_id,
  output logic                  tmr_en,
  output logic [WIDTH-1:0]      tmr_target,
  input  logic                  tmr_tick
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr, ptr_nxt;
  logic [NREQ-1:0]  gnt_nxt, done_nxt;
  logic             busy_nxt, en_nxt;
  logic [IDW-1:0]   id_nxt;
  logic [WIDTH-1:0] tgt_nxt;

  logic [WIDTH-1:0] dly_arr [NREQ];
  logic             any;
  logic [IDW-1:0]   pick;
  logic [IDW:0]     sum_a;
  logic [IDW:0]     sum_inc;
  logic [IDW-1:0]   ptr_inc;

  for (genvar g = 0; g < NREQ; g++) begin : g_dly
    assign dly_arr[g] = dly[g*WIDTH +: WIDTH];
  end

  // First pending request at or above ptr, wrapping around.
  always_comb begin
    any   = 1'b0;
    pick  = '0;
    sum_a = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum_a = {1'b0, ptr} + (IDW+1)'(i);
      if (sum_a >= NREQ_W) sum_a = sum_a - NREQ_W;
      if (!any && req[sum_a[IDW-1:0]]) begin
        any  = 1'b1;
        pick = sum_a[IDW-1:0];
      end
    end
  end

  assign sum_inc = {1'b0, cur_id} + (IDW+1)'(1);
  assign ptr_inc = (sum_inc == NREQ_W) ? '0 : sum_inc[IDW-1:0];

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    done_nxt  = '0;
    busy_nxt  = busy;
    id_nxt    = cur_id;
    en_nxt    = tmr_en;
    tgt_nxt   = tmr_target;
    case (state)
      IDLE: begin
        en_nxt = 1'b0;
        if (any) begin
          gnt_nxt   = NREQ'(1) << pick;
          id_nxt    = pick;
          tgt_nxt   = dly_arr[pick];
          en_nxt    = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
`ifdef TSCHED_ABORT_EN
        if (!req[cur_id]) begin
          en_nxt    = 1'b0;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
          ptr_nxt   = ptr_inc;
          state_nxt = IDLE;
        end else
`endif
        if (tmr_tick) begin
          done_nxt  = NREQ'(1) << cur_id;
          en_nxt    = 1'b0;
          gnt_nxt   = '0;
          ptr_nxt   = ptr_inc;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Extra idle slot lets the finished requester withdraw before rearbitration.
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt        <= '0;
      done       <= '0;
      busy       <= 1'b0;
      cur_id     <= '0;
      tmr_en     <= 1'b0;
      tmr_target <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      gnt        <= gnt_nxt;
      done       <= done_nxt;
      busy       <= busy_nxt;
      cur_id     <= id_nxt;
      tmr_en     <= en_nxt;
      tmr_target <= tgt_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_timer_sched.sv
// tb_timer_sched: scoreboard bench for timer_sched with a behavioural model of the shared timer.
// Revision: 1.0
`default_nettype none

module tb_timer_sched;

  localparam int W = 24;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] dly = '0;
  logic [N-1:0]   gnt, done;
  logic           busy;
  logic [1:0]     cur_id;
  logic           tmr_en;
  logic [W-1:0]   tmr_target;
  logic           tmr_tick;

  timer_sched #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .dly(dly),
    .gnt(gnt), .done(done), .busy(busy), .cur_id(cur_id),
    .tmr_en(tmr_en), .tmr_target(tmr_target), .tmr_tick(tmr_tick)
  );

  always #5 clk = ~clk;

  // Timer: cleared while disabled, ticks d+1 enabled edges after enable.
  logic [W-1:0] tcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0; tmr_tick <= 1'b0;
    end else if (!tmr_en) begin
      tcnt <= '0; tmr_tick <= 1'b0;
    end else if (tcnt >= tmr_target) begin
      tcnt <= '0; tmr_tick <= 1'b1;
    end else begin
      tcnt <= tcnt + 1'b1; tmr_tick <= 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; int d; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0, n_err = 0;
  int last_gnt_cyc = -1, spacing_exp = 0, en_cnt = 0, lo_cnt = 0, ndone = 0;
  logic [N-1:0] prev_gnt = '0, drop_mask = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  task automatic push(input int id, input int d);
    exp_q.push_back('{id: id, d: d});
    dly[id*W +: W] = W'(d);
  endtask

  task automatic monitor();
    exp_t e;
    if (gnt != '0 && prev_gnt == '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_gnt", 64'(gnt), 64'd0);
      end else begin
        check("gnt", 64'(gnt), 64'(oh(exp_q[0].id)));
        check("cur_id", 64'(cur_id), 64'(exp_q[0].id));
        check("tmr_target", 64'(tmr_target), 64'(exp_q[0].d));
        check("busy_at_gnt", 64'(busy), 64'd1);
        if (last_gnt_cyc >= 0) begin
          check("en_gap", 64'(lo_cnt >= 2), 64'd1);
          if (spacing_exp != 0) check("gnt_spacing", 64'(cyc - last_gnt_cyc), 64'(spacing_exp));
        end
      end
      last_gnt_cyc = cyc;
      en_cnt = 0;
    end
    prev_gnt = gnt;
    if (tmr_en) begin
      en_cnt++; lo_cnt = 0;
    end else begin
      lo_cnt++;
    end
    if (done != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("done", 64'(done), 64'(oh(e.id)));
        check("latency", 64'(cyc - last_gnt_cyc), 64'(e.d + 2));
        check("en_cycles", 64'(en_cnt), 64'(e.d + 2));
        req = req & ~(done & drop_mask);
      end
      ndone++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_gnt(input int budget);
    int n = 0;
    while (gnt == '0 && n < budget) begin tick(); n++; end
    if (gnt == '0) check("gnt_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_until_done(input int target, input int budget);
    int n = 0;
    while (ndone < target && n < budget) begin tick(); n++; end
    if (ndone < target) check("done_timeout", 64'(ndone), 64'(target));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    prev_gnt = '0;
    last_gnt_cyc = -1;
  endtask

  task automatic start_test(input logic [N-1:0] mask, input int spacing);
    ndone = 0; drop_mask = mask; spacing_exp = spacing; last_gnt_cyc = -1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_state", 64'({gnt, done, busy, cur_id, tmr_en, tmr_target}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a service.
    start_test('1, 0);
    push(2, 20); req = 4'b0100;
    wait_gnt(10);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("reset_mid", 64'({gnt, done, busy, cur_id, tmr_en, tmr_target}), 64'd0);
    exp_q.delete(); req = '0;
    @(negedge clk);
    rst_n = 1'b1; prev_gnt = '0;
    tick();

    // Single requester, d=5.
    start_test('1, 0);
    push(0, 5); req = 4'b0001;
    run_until_done(1, 40);
    tick();
    check("busy_after_done", 64'(busy), 64'd0);
    check("done_one_cycle", 64'(done), 64'd0);
    check("en_after_done", 64'(tmr_en), 64'd0);

    // Zero delay.
    start_test('1, 0);
    push(1, 0); req = 4'b0010;
    run_until_done(1, 20);
    repeat (2) tick();

    // All four requesters, each drops after its done.
    do_reset();
    start_test('1, 6);
    for (int i = 0; i < N; i++) push(i, 2);
    req = 4'b1111;
    run_until_done(4, 100);
    repeat (4) tick();
    check("four_dones", 64'(ndone), 64'd4);

    // Two requesters held permanently alternate.
    start_test('0, 7);
    push(0, 3); push(1, 3); push(0, 3); push(1, 3);
    req = 4'b0011;
    run_until_done(4, 100);
    req = '0;
    repeat (5) tick();
    check("alt_queue_empty", 64'(exp_q.size()), 64'd0);
    check("alt_dones", 64'(ndone), 64'd4);

    // Requester withdraws mid-service.
    start_test('1, 0);
    push(0, 10); req = 4'b0001;
    wait_gnt(10);
    repeat (4) tick();
    req = '0;
    tick();
`ifdef TSCHED_ABORT_EN
    check("abort_en", 64'(tmr_en), 64'd0);
    check("abort_gnt", 64'(gnt), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    exp_q.delete();
    repeat (12) tick();
    check("abort_no_done", 64'(ndone), 64'd0);
`else
    check("noabort_en", 64'(tmr_en), 64'd1);
    run_until_done(1, 20);
    check("noabort_done", 64'(ndone), 64'd1);
`endif
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
